// File: rtl/layer_header_sequencer.sv
// Walks every layer of the register bank once per frame and hands each header,
// tagged with its layer index, downstream over valid/ready. Optional macro: LAYER_SKIP_EN.
module layer_header_sequencer #(
   parameter int NUM_LAYERS = 32,
   parameter int LAYER_W    = 5,
   parameter int HDR_W      = 128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_start,
   output logic [LAYER_W-1:0] pipe_layer,
   input  logic [HDR_W-1:0]   pipe_allRegisters,
   output logic               hdr_valid,
   input  logic               hdr_ready,
   output logic [HDR_W-1:0]   hdr_data,
   output logic [LAYER_W-1:0] hdr_layer,
   output logic               busy,
   output logic               frame_done,
   output logic               overrun
);

   localparam logic [LAYER_W-1:0] LAST = LAYER_W'(NUM_LAYERS - 1);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CAPT, S_OUT, S_DONE} state_t;

   state_t             r_state, w_state_nxt;
   logic [LAYER_W-1:0] r_cnt, w_cnt_nxt;
   logic [LAYER_W-1:0] r_pl, w_pl_nxt;
   logic [LAYER_W-1:0] r_hl, w_hl_nxt;
   logic [HDR_W-1:0]   r_data, w_data_nxt;
   logic               r_vld, w_vld_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_ovr, w_ovr_nxt;
   logic               w_last;
   logic               w_emit;

   assign w_last = (r_cnt == LAST);

   // Bit 0 of register 0 is the layer enable; it only matters when skipping is built in.
`ifdef LAYER_SKIP_EN
   assign w_emit = pipe_allRegisters[0];
`else
   assign w_emit = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_pl    <= '0;
         r_hl    <= '0;
         r_data  <= '0;
         r_vld   <= 1'b0;
         r_busy  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pl    <= w_pl_nxt;
         r_hl    <= w_hl_nxt;
         r_data  <= w_data_nxt;
         r_vld   <= w_vld_nxt;
         r_busy  <= w_busy_nxt;
         r_ovr   <= w_ovr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pl_nxt    = r_pl;
      w_hl_nxt    = r_hl;
      w_data_nxt  = r_data;
      w_vld_nxt   = r_vld;
      w_busy_nxt  = r_busy;
      // A start request outside IDLE (including the DONE cycle) is dropped but remembered.
      w_ovr_nxt   = r_ovr | (frame_start && (r_state != S_IDLE));
      case (r_state)
         S_IDLE: begin
            if (frame_start) begin
               w_state_nxt = S_ADDR;
               w_cnt_nxt   = '0;
               w_pl_nxt    = '0;
               w_busy_nxt  = 1'b1;
            end
         end
         S_ADDR: w_state_nxt = S_CAPT;
         S_CAPT: begin
            if (w_emit) begin
               w_data_nxt  = pipe_allRegisters;
               w_hl_nxt    = r_cnt;
               w_vld_nxt   = 1'b1;
               w_state_nxt = S_OUT;
            end else if (w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
               w_pl_nxt    = r_cnt + 1'b1;
               w_state_nxt = S_ADDR;
            end
         end
         S_OUT: begin
            if (r_vld && hdr_ready) begin
               w_vld_nxt = 1'b0;
               if (w_last) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_cnt_nxt   = r_cnt + 1'b1;
                  w_pl_nxt    = r_cnt + 1'b1;
                  w_state_nxt = S_ADDR;
               end
            end
         end
         S_DONE: begin
            w_busy_nxt  = 1'b0;
            w_pl_nxt    = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign pipe_layer = r_pl;
   assign hdr_valid  = r_vld;
   assign hdr_data   = r_data;
   assign hdr_layer  = r_hl;
   assign busy       = r_busy;
   assign frame_done = (r_state == S_DONE);
   assign overrun    = r_ovr;

endmodule

// File: tb/tb_layer_header_sequencer.sv
// Randomized bench for layer_header_sequencer: a bank model with one-cycle read
// latency, an expected-header queue derived from the enable rule, and latency checks.
module tb_layer_header_sequencer;
   localparam int N  = 32;
   localparam int LW = 5;
   localparam int HW = 128;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_start = 1'b0;
   logic          hdr_ready = 1'b0;
   logic [LW-1:0] pipe_layer, hdr_layer;
   logic [HW-1:0] pipe_allRegisters, hdr_data;
   logic          hdr_valid, busy, frame_done, overrun;

   always #5 clk = ~clk;

   layer_header_sequencer #(.NUM_LAYERS(N), .LAYER_W(LW), .HDR_W(HW)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .pipe_layer(pipe_layer),
      .pipe_allRegisters(pipe_allRegisters), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
      .hdr_data(hdr_data), .hdr_layer(hdr_layer), .busy(busy), .frame_done(frame_done),
      .overrun(overrun)
   );

   logic [HW-1:0] bank [N];
   always @(posedge clk) pipe_allRegisters <= bank[pipe_layer];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int hs_cnt  = 0;
   int done_cnt = 0;
   int exp_emit = 0;
   int exp_base = 0;

   typedef struct {
      int            layer;
      logic [HW-1:0] data;
   } hdr_t;
   hdr_t expq[$];

   task automatic chk(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: the headers a frame should produce, in order, and its ideal latency.
   task automatic build_exp();
      int e = 0;
      int s = 0;
      bit en;
      expq.delete();
      for (int i = 0; i < N; i++) begin
`ifdef LAYER_SKIP_EN
         en = bank[i][0];
`else
         en = 1'b1;
`endif
         if (en) begin
            hdr_t h;
            h.layer = i;
            h.data  = bank[i];
            expq.push_back(h);
            e++;
         end else begin
            s++;
         end
      end
      exp_emit = e;
      exp_base = 3 * e + 2 * s + 1;
   endtask

   task automatic fill_bank(input int mode);
      for (int i = 0; i < N; i++) begin
         bank[i] = {$urandom, $urandom, $urandom, $urandom};
         case (mode)
            0: bank[i] = HW'(i) | HW'(1);
            1: bank[i][0] = 1'b1;
            2: bank[i][0] = (i == 2 || i == 30);
            3: bank[i][0] = 1'b0;
            default: ;
         endcase
      end
   endtask

   // Monitor: every handshake is checked against the queue; stalled outputs must hold.
   initial begin
      logic          p_vld, p_rdy;
      logic [HW-1:0] p_data;
      logic [LW-1:0] p_layer, p_pl;
      hdr_t          h;
      p_vld = 1'b0; p_rdy = 1'b0; p_data = '0; p_layer = '0; p_pl = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            p_vld = 1'b0;
         end else begin
            if (p_vld && !p_rdy) begin
               chk("stall_valid", HW'(hdr_valid), HW'(1));
               chk("stall_data", hdr_data, p_data);
               chk("stall_layer", HW'(hdr_layer), HW'(p_layer));
               chk("stall_pipe_layer", HW'(pipe_layer), HW'(p_pl));
            end
            if (hdr_valid && hdr_ready) begin
               hs_cnt++;
               if (expq.size() == 0) begin
                  chk("hs_unexpected", HW'(1), HW'(0));
               end else begin
                  h = expq.pop_front();
                  chk("hs_layer", HW'(hdr_layer), HW'(h.layer));
                  chk("hs_data", hdr_data, h.data);
               end
            end
            if (frame_done) done_cnt++;
            p_vld = hdr_valid; p_rdy = hdr_ready; p_data = hdr_data;
            p_layer = hdr_layer; p_pl = pipe_layer;
         end
      end
   end

   // mode 0: ready high; 1: random ready; 2: 10-cycle stall on layer 3.
   task automatic run_frame(input int mode, input int ovr_at, input bit chk_lat);
      int  start, dl, stall, hs0;
      bit  done, pl4;
      build_exp();
      hs0 = hs_cnt;
      stall = 0; done = 1'b0; pl4 = 1'b0; dl = 0;
      @(posedge clk); #1;
      frame_start = 1'b1;
      hdr_ready = 1'b1;
      start = cyc;
      for (int k = 0; k < 3000 && !done; k++) begin
         @(posedge clk); #1;
         frame_start = (k + 1 == ovr_at);
         if (k == 0) chk("busy_on", HW'(busy), HW'(1));
         if (frame_done) begin
            done = 1'b1;
            dl = cyc - start;
         end
         case (mode)
            1: hdr_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (hdr_valid && hdr_layer == LW'(3) && stall < 10) begin
                  hdr_ready = 1'b0;
                  stall++;
                  chk("bp_pipe_layer", HW'(pipe_layer), HW'(3));
               end else begin
                  hdr_ready = 1'b1;
                  if (stall == 10 && !pl4 && !hdr_valid) begin
                     chk("bp_next_addr", HW'(pipe_layer), HW'(4));
                     pl4 = 1'b1;
                  end
               end
            end
            default: hdr_ready = 1'b1;
         endcase
      end
      frame_start = 1'b0;
      if (!done) begin
         chk("done_timeout", HW'(0), HW'(1));
      end else if (chk_lat) begin
         chk("done_latency", HW'(dl), HW'(exp_base + (mode == 2 ? 10 : 0)));
      end
      @(posedge clk); #1;
      chk("busy_off", HW'(busy), HW'(0));
      chk("done_pulse", HW'(frame_done), HW'(0));
      chk("idle_pipe_layer", HW'(pipe_layer), HW'(0));
      chk("hs_count", HW'(hs_cnt - hs0), HW'(exp_emit));
      chk("hs_missing", HW'(expq.size()), HW'(0));
   endtask

   initial begin
      int  d0;
      bit  hit;
      fill_bank(0);
      repeat (2) @(negedge clk);
      chk("rst_pipe_layer", HW'(pipe_layer), HW'(0));
      chk("rst_valid", HW'(hdr_valid), HW'(0));
      chk("rst_data", hdr_data, HW'(0));
      chk("rst_layer", HW'(hdr_layer), HW'(0));
      chk("rst_busy", HW'(busy), HW'(0));
      chk("rst_done", HW'(frame_done), HW'(0));
      chk("rst_overrun", HW'(overrun), HW'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      fill_bank(0); run_frame(0, 0, 1);
      fill_bank(4); run_frame(1, 0, 0);
      fill_bank(1); run_frame(1, 0, 0);
      fill_bank(1); run_frame(2, 0, 1);
      chk("overrun_clear", HW'(overrun), HW'(0));
      fill_bank(4); run_frame(0, 5, 1);
      chk("overrun_set", HW'(overrun), HW'(1));
      fill_bank(2); run_frame(0, 0, 1);
      chk("overrun_sticky", HW'(overrun), HW'(1));
      fill_bank(3); run_frame(0, 0, 1);
      fill_bank(4); run_frame(0, 0, 1);
      fill_bank(4); run_frame(1, 0, 0);

      // Abort while layer 5 is held in the output stage.
      fill_bank(1);
      build_exp();
      @(posedge clk); #1;
      frame_start = 1'b1;
      hdr_ready = 1'b1;
      hit = 1'b0;
      for (int k = 0; k < 500 && !hit; k++) begin
         @(posedge clk); #1;
         frame_start = 1'b0;
         if (hdr_valid && hdr_layer == LW'(5)) begin
            hdr_ready = 1'b0;
            hit = 1'b1;
         end
      end
      if (!hit) chk("abort_timeout", HW'(0), HW'(1));
      @(posedge clk); #1;
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      chk("abort_valid", HW'(hdr_valid), HW'(0));
      chk("abort_data", hdr_data, HW'(0));
      chk("abort_layer", HW'(hdr_layer), HW'(0));
      chk("abort_pipe_layer", HW'(pipe_layer), HW'(0));
      chk("abort_busy", HW'(busy), HW'(0));
      chk("abort_overrun", HW'(overrun), HW'(0));
      expq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      hdr_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_done", HW'(done_cnt), HW'(d0));
      chk("abort_idle_busy", HW'(busy), HW'(0));
      fill_bank(4); run_frame(0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
